fast_division_1: RTL and testbench

Two-cycle radix-4 fixed-point divider for unsigned 4-bit operands. It returns the quotient in Q2.2 format, with 2 integer bits and 2 fraction bits, computed as floor(4·dividend/divisor). One radix-4 digit is resolved per clock, so a result is ready two clock edges after `start`. It is a standalone arithmetic block with a one-cycle `start` pulse in and a `done` pulse out.

---
 rtl/fast_division_1.sv | 135 +++++++++++++
 tb/tb_fast_division_1.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_division_1.sv
// fast_division_1: two-cycle radix-4 divider for unsigned 4-bit operands.
// Produces floor(4*dividend/divisor) as a Q2.2 value, one radix-4 digit per clock.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   start    - one-cycle request; dividend/divisor sampled on the same edge
//   dividend - unsigned 4-bit numerator
//   divisor  - unsigned 4-bit denominator
//   quotient - registered Q2.2 result ([3:2] integer, [1:0] quarters)
//   done     - one-cycle pulse when quotient/ovf update
//   ovf      - registered overflow flag (divide by zero or integer part > 3)
module fast_division_1 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] quotient,
    output logic       done,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIG2 = 2'b01
    } state_t;

    state_t state, next_state;
    logic   load, finish;

    // Registered digit-1 results carried into the second cycle
    logic [3:0] div_r;
    logic [1:0] q1_r;
    logic [3:0] r1_r;
    logic       ovf_r;

    // ---------------- Digit 1: combinational from live inputs ----------------
    logic [5:0] a6, d1, d2, d3, prod1;
    logic [1:0] q1_c;
    logic [3:0] r1_c;
    logic       ovf_c;

    always_comb begin
        a6 = {2'b00, dividend};
        d1 = {2'b00, divisor};
        d2 = {1'b0, divisor, 1'b0};
        d3 = d1 + d2;

        if (d3 <= a6)      q1_c = 2'd3;
        else if (d2 <= a6) q1_c = 2'd2;
        else if (d1 <= a6) q1_c = 2'd1;
        else               q1_c = 2'd0;

        case (q1_c)
            2'd1:    prod1 = d1;
            2'd2:    prod1 = d2;
            2'd3:    prod1 = d3;
            default: prod1 = '0;
        endcase

        // Remainder is below divisor whenever the result is representable,
        // so truncation to 4 bits is lossless in that case.
        r1_c  = 4'(a6 - prod1);
        ovf_c = (divisor == 4'd0) || (a6 >= {divisor, 2'b00});
    end

    // ---------------- Digit 2: from registered remainder ----------------
    logic [5:0] pr, e1, e2, e3;
    logic [1:0] q0_c;

    always_comb begin
        pr = {r1_r, 2'b00};
        e1 = {2'b00, div_r};
        e2 = {1'b0, div_r, 1'b0};
        e3 = e1 + e2;

        if (e3 <= pr)      q0_c = 2'd3;
        else if (e2 <= pr) q0_c = 2'd2;
        else if (e1 <= pr) q0_c = 2'd1;
        else               q0_c = 2'd0;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // start wins in every state (including illegal encodings), aborting any
    // operation in flight before its result is written.
    always_comb begin
        next_state = IDLE;
        load       = 1'b0;
        finish     = 1'b0;
        if (start) begin
            next_state = DIG2;
            load       = 1'b1;
        end else begin
            case (state)
                DIG2: begin
                    next_state = IDLE;
                    finish     = 1'b1;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r    <= '0;
            q1_r     <= '0;
            r1_r     <= '0;
            ovf_r    <= 1'b0;
            quotient <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                div_r <= divisor;
                q1_r  <= q1_c;
                r1_r  <= r1_c;
                ovf_r <= ovf_c;
            end
            if (finish) begin
                quotient <= ovf_r ? 4'hF : {q1_r, q0_c};
                ovf      <= ovf_r;
            end
        end
    end

endmodule

// File: tb/tb_fast_division_1.sv
module tb_fast_division_1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic       done;
    logic       ovf;

    int compared   = 0;
    int mismatched = 0;

    // Scoreboard of expected {ovf, quotient}
    logic [4:0] exp_q[$];

    fast_division_1 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ref_div(input int a, input int b);
        int q;
        if (b == 0 || a >= 4 * b) return {1'b1, 4'hF};
        q = (4 * a) / b;
        return {1'b0, q[3:0]};
    endfunction

    // Drive one start pulse and record the expected result.
    task automatic issue(input int a, input int b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a[3:0];
        divisor  = b[3:0];
        exp_q.push_back(ref_div(a, b));
        @(negedge clk);
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
    endtask

    // Bounded wait for done, sampled on falling edges.
    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; start = 1'b1; dividend = 4'd7; divisor = 4'd2;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        compared++;
        if (quotient !== 4'd0 || done !== 1'b0 || ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: q=%h done=%b ovf=%b, want q=0 done=0 ovf=0", quotient, done, ovf);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (done !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_over_start: done=%b want 0", done);
            end
        end
    endtask

    task automatic test_basic;
        int as[2] = '{7, 13};
        int bs[2] = '{2, 4};
        bit got;
        logic [4:0] e;
        for (int k = 0; k < 2; k++) begin
            issue(as[k], bs[k]);
            wait_done(got);
            e = exp_q.pop_front();
            compared++;
            if (!got || quotient !== e[3:0] || ovf !== e[4]) begin
                mismatched++;
                $display("FAIL basic_%0d_%0d: got=%b q=%b ovf=%b, want q=%b ovf=%b",
                         as[k], bs[k], got, quotient, ovf, e[3:0], e[4]);
            end
            @(negedge clk);
            compared++;
            if (done !== 1'b0) begin
                mismatched++;
                $display("FAIL done_width: done=%b want 0", done);
            end
        end
        compared++;
        if (quotient[3:2] !== 2'd3 || quotient[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL q_13_4_fields: int=%0d q1=%b, want int=3 q1=0", quotient[3:2], quotient[1]);
        end
    endtask

    task automatic test_overflow;
        int as[4] = '{5, 1, 8, 0};
        int bs[4] = '{0, 1, 2, 9};
        bit got;
        logic [4:0] e;
        for (int k = 0; k < 4; k++) begin
            issue(as[k], bs[k]);
            wait_done(got);
            e = exp_q.pop_front();
            compared++;
            if (!got || quotient !== e[3:0] || ovf !== e[4]) begin
                mismatched++;
                $display("FAIL ovf_case_%0d_%0d: got=%b q=%h ovf=%b, want q=%h ovf=%b",
                         as[k], bs[k], got, quotient, ovf, e[3:0], e[4]);
            end
            if (k == 0) begin
                repeat (3) @(negedge clk);
                compared++;
                if (quotient !== 4'hF || ovf !== 1'b1) begin
                    mismatched++;
                    $display("FAIL ovf_hold: q=%h ovf=%b, want q=f ovf=1", quotient, ovf);
                end
            end
        end
    endtask

    task automatic test_abort;
        bit got;
        logic [4:0] e;
        @(negedge clk);
        start = 1'b1; dividend = 4'd9; divisor = 4'd3;
        @(negedge clk);
        dividend = 4'd2; divisor = 4'd8;
        exp_q.push_back(ref_div(2, 8));
        @(negedge clk);
        start = 1'b0; dividend = 4'd15; divisor = 4'd1;
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_no_done: done=%b want 0", done);
        end
        wait_done(got);
        e = exp_q.pop_front();
        compared++;
        if (!got || quotient !== e[3:0] || ovf !== e[4]) begin
            mismatched++;
            $display("FAIL abort_result: got=%b q=%b ovf=%b, want q=%b ovf=%b", got, quotient, ovf, e[3:0], e[4]);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_single_done: done=%b want 0", done);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] e;
        issue(11, 5);
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if (done !== 1'b1 || quotient !== e[3:0] || ovf !== e[4]) begin
            mismatched++;
            $display("FAIL b2b_first: done=%b q=%b ovf=%b, want done=1 q=%b ovf=%b", done, quotient, ovf, e[3:0], e[4]);
        end
        start = 1'b1; dividend = 4'd3; divisor = 4'd7;
        exp_q.push_back(ref_div(3, 7));
        @(negedge clk);
        start = 1'b0;
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_gap: done=%b want 0", done);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if (done !== 1'b1 || quotient !== e[3:0] || ovf !== e[4]) begin
            mismatched++;
            $display("FAIL b2b_second: done=%b q=%b ovf=%b, want done=1 q=%b ovf=%b", done, quotient, ovf, e[3:0], e[4]);
        end
    endtask

    task automatic test_reset_mid;
        issue(13, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        compared++;
        if (done !== 1'b0 || quotient !== 4'd0 || ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid: done=%b q=%h ovf=%b, want 0 0 0", done, quotient, ovf);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (done !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_mid_no_done: done=%b want 0", done);
            end
        end
    endtask

    task automatic test_sweep;
        bit got;
        logic [4:0] e;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(a, b);
                wait_done(got);
                e = exp_q.pop_front();
                compared++;
                if (!got || quotient !== e[3:0] || ovf !== e[4]) begin
                    mismatched++;
                    $display("FAIL sweep_%0d_%0d: got=%b q=%b ovf=%b, want q=%b ovf=%b",
                             a, b, got, quotient, ovf, e[3:0], e[4]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
